traffic_ctrl: RTL and testbench
===============================

# traffic_ctrl

Parametrised multi-approach traffic-light controller: the timed, sequencing successor to the single-approach lamp decoder. It cycles N_DIR approaches through green, green+yellow warning, yellow and all-red phases, with durations counted in `tick` periods. Vehicle requests reorder service, and a maintenance flash mode overrides the sequence. It sits between the board prescaler, which supplies `tick`, and the lamp-driver pins.

## Interface
- N_DIR, 2: number of approaches; must be ≥2.
- GREEN_T, 20: green duration in ticks, including the warning; must be ≥2.
- WARN_T, 3: final green ticks shown as green+yellow; must satisfy 1 ≤ WARN_T < GREEN_T.
- YELLOW_T, 4: yellow duration in ticks; must be ≥1.
- ALLRED_T, 2: all-red clearance in ticks; must be ≥1.
- CNT_W, 8: tick-counter width; must hold max(duration)−1.
- clk  in  1  system clock; one clock domain only.
- rst  in  1  asynchronous, active-high reset.
- tick  in  1  one-clk-wide timing enable from the prescaler.
- req  in  N_DIR  level vehicle request per approach.
- flash  in  1  maintenance mode, level.
- green  out  N_DIR  green lamp per approach.
- yellow  out  N_DIR  yellow lamp per approach.
- red  out  N_DIR  red lamp per approach.
- phase  out  max(1,$clog2(N_DIR))  index of the approach being served.

## Operation
- States: ALLRED, GREEN, YELLOW, FLASH.
- Reset values:
  - state=ALLRED, cnt=ALLRED_T−1, phase=N_DIR−1.
  - red=all 1, green=0, yellow=0.
- Dwell counter:
  - On entry to a timed state, load duration−1.
  - On each `tick`: if cnt≠0, decrement; if cnt=0, take the transition.
  - Without `tick`, the state and counter hold.
  - Each timed state therefore lasts exactly its duration in ticks.
- ALLRED→GREEN:
  - Choose the next phase: the first approach with `req` set, searching cyclically from phase+1 through phase.
  - If `req`=0, choose phase+1, wrapping N_DIR−1→0.
- GREEN→YELLOW and YELLOW→ALLRED: phase is unchanged.
- Lamps, for approach i=phase:
  - GREEN with cnt ≥ WARN_T: green only.
  - GREEN with cnt < WARN_T: green+yellow.
  - YELLOW: yellow only.
  - ALLRED: red only.
- Lamps, for approaches other than phase, in every non-FLASH state: red only.
- FLASH:
  - flash=1 is checked every clk with priority over all transitions.
  - The next clk enters FLASH: red=0, green=0, and yellow=all 1 toggles (all bits together) on each tick.
  - phase is frozen.
  - flash=0 in FLASH: the next clk enters ALLRED with cnt=ALLRED_T−1 and yellow cleared.
- Simultaneous tick and flash: flash wins and the tick is ignored.
- Reset mid-sequence: immediate return to reset values; no partial phase resumes.
- Invariant: at most one approach has green or yellow set outside FLASH.

## Timing
- All outputs are registered and updated on the same clk edge as the state register; they are decoded from the next-state value.
- The output change is visible at the first clk edge after the triggering input (`tick` or `flash`): 1-clk latency, no combinational paths from inputs to outputs.
- `req` is sampled only on the ALLRED-exit edge. A request asserted and dropped between exits is lost, by design.
- Full cycle with requests idle: N_DIR × (GREEN_T + YELLOW_T + ALLRED_T) ticks.

## Structure
- Shared package/header `traffic_pkg`:
  - state encoding constants ST_ALLRED, ST_GREEN, ST_YELLOW, ST_FLASH.
  - lamp code constants: LC_RED=2'b00, LC_YEL=2'b01, LC_GRN=2'b10, LC_WARN=2'b11. These keep the existing 2-bit lamp code compatible.
- Sub-module `traffic_rr_next`:
  - Purely combinational, parametrised by N_DIR.
  - Inputs: current phase, req. Output: next phase per the search rule above.
- Top level holds the FSM, the dwell counter and the lamp decode.

## Test plan
Conditions: N_DIR=2, GREEN_T=5, WARN_T=1, YELLOW_T=2, ALLRED_T=1, `tick` every clk unless stated.
- Reset, req=0:
  - red=2'b11 for 1 clk.
  - Then phase=0 with green[0]=1 for 4 clk, then green[0]=yellow[0]=1 for 1 clk.
  - Then yellow[0] for 2 clk, red for 1 clk, then green[1].
- `tick` every 4th clk: every dwell stretches exactly ×4, and lamps never change between ticks.
- N_DIR=3, req=3'b100 held: service goes 0→2→2→2…, and approach 1 is never green.
- flash=1 for 6 clk during GREEN phase 1:
  - The next clk shows red=0, green=0, yellow=all 1, toggling each clk.
  - After release: ALLRED for 1 tick, then green for phase (1+1) mod 2 = 0.
- rst pulsed mid-YELLOW (between clk edges): outputs go to reset values immediately, without waiting for a clk edge. The sequence then restarts exactly as in scenario 1.
- Every clk, check assertion: popcount(green|yellow) ≤ 1 outside FLASH, and red[i] = ~(green[i]|yellow[i]).

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared state encoding and 2-bit lamp codes for the multi-approach traffic controller.
package traffic_pkg;

    typedef enum logic [1:0] {
        ST_ALLRED = 2'd0,
        ST_GREEN  = 2'd1,
        ST_YELLOW = 2'd2,
        ST_FLASH  = 2'd3
    } state_t;

    // Bit 1 drives the green lamp, bit 0 the yellow lamp; 00 leaves the approach red.
    localparam logic [1:0] LC_RED  = 2'b00;
    localparam logic [1:0] LC_YEL  = 2'b01;
    localparam logic [1:0] LC_GRN  = 2'b10;
    localparam logic [1:0] LC_WARN = 2'b11;

    function automatic logic [1:0] lamp_code(input state_t st, input logic warn);
        logic [1:0] code;
        code = LC_RED;
        case (st)
            ST_GREEN:  code = warn ? LC_WARN : LC_GRN;
            ST_YELLOW: code = LC_YEL;
            default:   code = LC_RED;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/traffic_rr_next.sv
// Picks the next approach to serve: first requester after the current phase, cyclically,
// or simply the following approach when nobody is requesting.
module traffic_rr_next
    import traffic_pkg::*;
#(
    parameter int N_DIR = 2,
    parameter int PH_W  = (N_DIR > 1) ? $clog2(N_DIR) : 1
) (
    input  logic [PH_W-1:0]  i_phase,
    input  logic [N_DIR-1:0] i_req,
    output logic [PH_W-1:0]  o_next
);

    logic [N_DIR-1:0] w_rot;
    int               w_off;
    int               w_sum;

    always_comb begin
        // w_rot[k] is the request of approach (phase + 1 + k) mod N_DIR.
        w_rot = N_DIR'({i_req, i_req} >> (int'(i_phase) + 1));
        w_off = 0;
        for (int k = N_DIR - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = k;
            end
        end
        w_sum = int'(i_phase) + 1 + w_off;
        if (w_sum >= N_DIR) begin
            w_sum = w_sum - N_DIR;
        end
        o_next = PH_W'(w_sum);
    end

endmodule

// File: rtl/traffic_ctrl.sv
// Timed traffic-light sequencer for N_DIR approaches with request-driven ordering
// and a maintenance flash override; all lamp outputs are registered.
module traffic_ctrl
    import traffic_pkg::*;
#(
    parameter int N_DIR    = 2,
    parameter int GREEN_T  = 20,
    parameter int WARN_T   = 3,
    parameter int YELLOW_T = 4,
    parameter int ALLRED_T = 2,
    parameter int CNT_W    = 8,
    parameter int PH_W     = (N_DIR > 1) ? $clog2(N_DIR) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic [N_DIR-1:0] req,
    input  logic             flash,
    output logic [N_DIR-1:0] green,
    output logic [N_DIR-1:0] yellow,
    output logic [N_DIR-1:0] red,
    output logic [PH_W-1:0]  phase
);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [PH_W-1:0]  r_phase;
    logic [N_DIR-1:0] r_green;
    logic [N_DIR-1:0] r_yellow;
    logic [N_DIR-1:0] r_red;

    state_t           w_state;
    logic [CNT_W-1:0] w_cnt;
    logic [PH_W-1:0]  w_phase;
    logic [PH_W-1:0]  w_rr_next;
    logic [1:0]       w_code;
    logic [N_DIR-1:0] w_green;
    logic [N_DIR-1:0] w_yellow;
    logic [N_DIR-1:0] w_red;

    traffic_rr_next #(
        .N_DIR (N_DIR),
        .PH_W  (PH_W)
    ) u_rr_next (
        .i_phase (r_phase),
        .i_req   (req),
        .o_next  (w_rr_next)
    );

    // Flash has priority over every timed transition; a coincident tick is ignored.
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_phase = r_phase;
        if (flash) begin
            w_state = ST_FLASH;
        end else if (r_state == ST_FLASH) begin
            w_state = ST_ALLRED;
            w_cnt   = CNT_W'(ALLRED_T - 1);
        end else if (tick) begin
            if (r_cnt != '0) begin
                w_cnt = r_cnt - 1'b1;
            end else begin
                case (r_state)
                    ST_ALLRED: begin
                        w_state = ST_GREEN;
                        w_cnt   = CNT_W'(GREEN_T - 1);
                        w_phase = w_rr_next;
                    end
                    ST_GREEN: begin
                        w_state = ST_YELLOW;
                        w_cnt   = CNT_W'(YELLOW_T - 1);
                    end
                    ST_YELLOW: begin
                        w_state = ST_ALLRED;
                        w_cnt   = CNT_W'(ALLRED_T - 1);
                    end
                    default: ;
                endcase
            end
        end
    end

    // Lamps are decoded from the next state so they change on the same edge as the FSM.
    always_comb begin
        w_code   = lamp_code(w_state, w_cnt < CNT_W'(WARN_T));
        w_green  = '0;
        w_yellow = '0;
        w_red    = '1;
        if (w_state == ST_FLASH) begin
            w_red = '0;
            if (r_state == ST_FLASH) begin
                w_yellow = tick ? ~r_yellow : r_yellow;
            end else begin
                w_yellow = '1;
            end
        end else begin
            w_green[w_phase]  = w_code[1];
            w_yellow[w_phase] = w_code[0];
            w_red[w_phase]    = ~(w_code[1] | w_code[0]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_ALLRED;
            r_cnt    <= CNT_W'(ALLRED_T - 1);
            r_phase  <= PH_W'(N_DIR - 1);
            r_green  <= '0;
            r_yellow <= '0;
            r_red    <= '1;
        end else begin
            r_state  <= w_state;
            r_cnt    <= w_cnt;
            r_phase  <= w_phase;
            r_green  <= w_green;
            r_yellow <= w_yellow;
            r_red    <= w_red;
        end
    end

    assign green  = r_green;
    assign yellow = r_yellow;
    assign red    = r_red;
    assign phase  = r_phase;

endmodule

// File: tb/tb_traffic_ctrl.sv
// Self-checking bench for traffic_ctrl: reference model tracks position within each
// approach's red/green/yellow period in ticks rather than the RTL state machine.
module tb_traffic_ctrl;

    localparam int A = 1;          // all-red ticks
    localparam int G = 5;          // green ticks (including warning)
    localparam int W = 1;          // warning ticks
    localparam int Y = 2;          // yellow ticks
    localparam int P = A + G + Y;  // ticks per served approach

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic [1:0] req;
    logic       flash;
    logic [1:0] green, yellow, red;
    logic       phase;

    logic       tick3;
    logic [2:0] req3;
    logic       flash3;
    logic [2:0] green3, yellow3, red3;
    logic [1:0] phase3;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state
    logic m_flash;
    logic m_yel;
    int   m_pos;
    int   m_phase;

    // Expected {green, yellow, red, phase} right after reset release, one entry per clk.
    logic [6:0] seq_tbl [10] = '{7'b0000111, 7'b0100100, 7'b0100100, 7'b0100100,
                                 7'b0100100, 7'b0101100, 7'b0001100, 7'b0001100,
                                 7'b0000110, 7'b1000011};

    traffic_ctrl #(
        .N_DIR(2), .GREEN_T(G), .WARN_T(W), .YELLOW_T(Y), .ALLRED_T(A), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .req(req), .flash(flash),
        .green(green), .yellow(yellow), .red(red), .phase(phase)
    );

    traffic_ctrl #(
        .N_DIR(3), .GREEN_T(G), .WARN_T(W), .YELLOW_T(Y), .ALLRED_T(A), .CNT_W(8)
    ) dut3 (
        .clk(clk), .rst(rst), .tick(tick3), .req(req3), .flash(flash3),
        .green(green3), .yellow(yellow3), .red(red3), .phase(phase3)
    );

    always #5 clk = ~clk;

    function automatic int m_next(input int ph, input logic [1:0] rq);
        for (int k = 1; k <= 2; k++) begin
            if (rq[(ph + k) % 2]) return (ph + k) % 2;
        end
        return (ph + 1) % 2;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_flash = 1'b0;
            m_yel   = 1'b0;
            m_pos   = 0;
            m_phase = 1;
        end else if (flash) begin
            if (!m_flash) begin
                m_flash = 1'b1;
                m_yel   = 1'b1;
            end else if (tick) begin
                m_yel = ~m_yel;
            end
        end else if (m_flash) begin
            m_flash = 1'b0;
            m_yel   = 1'b0;
            m_pos   = 0;
        end else if (tick) begin
            m_pos = m_pos + 1;
            if (m_pos == A) m_phase = m_next(m_phase, req);
            if (m_pos == P) m_pos = 0;
        end
    end

    function automatic logic [6:0] model_out();
        logic [1:0] g, y, r;
        g = 2'b00;
        y = 2'b00;
        r = 2'b11;
        if (m_flash) begin
            r = 2'b00;
            y = {2{m_yel}};
        end else if (m_pos >= A) begin
            if (m_pos < A + G - W) begin
                g[m_phase] = 1'b1;
            end else if (m_pos < A + G) begin
                g[m_phase] = 1'b1;
                y[m_phase] = 1'b1;
            end else begin
                y[m_phase] = 1'b1;
            end
            r[m_phase] = 1'b0;
        end
        return {g, y, r, m_phase[0]};
    endfunction

    // Lamp invariants outside flash, every clk.
    always @(negedge clk) begin
        if (!rst && !m_flash) begin
            tests_run++;
            if ($countones(green | yellow) > 1 || red !== ~(green | yellow)) begin
                tests_failed++;
                $display("FAIL invariant t=%0t got g=%b y=%b r=%b required one lit approach, red=~(g|y)",
                         $time, green, yellow, red);
            end
        end
    end

    task automatic test_reset_seq(input string tag);
        @(negedge clk);
        tick  = 1'b1;
        flash = 1'b0;
        req   = 2'b00;
        rst   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 0) #1;
            else @(negedge clk);
            tests_run++;
            if ({green, yellow, red, phase} !== seq_tbl[i]) begin
                tests_failed++;
                $display("FAIL %s step=%0d got=%b required=%b", tag, i,
                         {green, yellow, red, phase}, seq_tbl[i]);
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        tests_run++;
        if ({green, yellow, red, phase} !== 7'b0000111) begin
            tests_failed++;
            $display("FAIL reset_vals got=%b required=%b", {green, yellow, red, phase}, 7'b0000111);
        end
        test_reset_seq("reset_seq");
    endtask

    task automatic test_n3();
        int         served = 0;
        logic [2:0] prev   = 3'b000;
        logic [2:0] exp_g;
        tick  = 1'b0;
        tick3 = 1'b1;
        for (int c = 0; c < 60 && served < 4; c++) begin
            @(negedge clk);
            tests_run++;
            if (green3[1] !== 1'b0 || red3 !== ~(green3 | yellow3)) begin
                tests_failed++;
                $display("FAIL n3_lamps c=%0d got g=%b y=%b r=%b required g[1]=0 and red=~(g|y)",
                         c, green3, yellow3, red3);
            end
            if (green3 != 3'b000 && prev == 3'b000) begin
                exp_g = (served == 0) ? 3'b001 : 3'b100;
                tests_run++;
                if (green3 !== exp_g) begin
                    tests_failed++;
                    $display("FAIL n3_service n=%0d got=%b required=%b", served, green3, exp_g);
                end
                served++;
                req3 = 3'b100;
            end
            prev = green3;
        end
        tests_run++;
        if (served < 4) begin
            tests_failed++;
            $display("FAIL n3_timeout got %0d services required 4", served);
        end
        tick3 = 1'b0;
        req3  = 3'b000;
    endtask

    task automatic test_tick4();
        for (int c = 0; c < 96; c++) begin
            @(negedge clk);
            tests_run++;
            if ({green, yellow, red, phase} !== model_out()) begin
                tests_failed++;
                $display("FAIL tick4 c=%0d got=%b required=%b", c, {green, yellow, red, phase}, model_out());
            end
            tick = (c % 4 == 0);
        end
    endtask

    task automatic test_flash();
        bit found = 0;
        tick = 1'b1;
        req  = 2'b00;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            tests_run++;
            if ({green, yellow, red, phase} !== model_out()) begin
                tests_failed++;
                $display("FAIL flash_pre c=%0d got=%b required=%b", c, {green, yellow, red, phase}, model_out());
            end
            if (!m_flash && m_phase == 1 && m_pos >= A && m_pos < A + G - W) found = 1;
        end
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("FAIL flash_wait got no green on phase 1 required one within 40 clk");
        end
        flash = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            tests_run++;
            if ({green, yellow, red, phase} !== model_out()) begin
                tests_failed++;
                $display("FAIL flash_on i=%0d got=%b required=%b", i, {green, yellow, red, phase}, model_out());
            end
            if (i == 0) begin
                tests_run++;
                if ({green, red, yellow} !== 6'b000011) begin
                    tests_failed++;
                    $display("FAIL flash_entry got g/r/y=%b required=%b", {green, red, yellow}, 6'b000011);
                end
            end
        end
        flash = 1'b0;
        found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            tests_run++;
            if ({green, yellow, red, phase} !== model_out()) begin
                tests_failed++;
                $display("FAIL flash_post c=%0d got=%b required=%b", c, {green, yellow, red, phase}, model_out());
            end
            if (green != 2'b00) begin
                found = 1;
                tests_run++;
                if (green !== 2'b01) begin
                    tests_failed++;
                    $display("FAIL flash_resume got green=%b required=%b", green, 2'b01);
                end
            end
        end
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("FAIL flash_resume_timeout got no green required green within 20 clk");
        end
    endtask

    task automatic test_reset_mid();
        bit found = 0;
        tick = 1'b1;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            tests_run++;
            if ({green, yellow, red, phase} !== model_out()) begin
                tests_failed++;
                $display("FAIL mid_pre c=%0d got=%b required=%b", c, {green, yellow, red, phase}, model_out());
            end
            if (!m_flash && m_pos >= A + G) found = 1;
        end
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("FAIL mid_wait got no yellow required yellow within 40 clk");
        end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if ({green, yellow, red, phase} !== 7'b0000111) begin
            tests_failed++;
            $display("FAIL mid_async got=%b required=%b", {green, yellow, red, phase}, 7'b0000111);
        end
        test_reset_seq("mid_restart");
    endtask

    task automatic test_random();
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            tests_run++;
            if ({green, yellow, red, phase} !== model_out()) begin
                tests_failed++;
                $display("FAIL random c=%0d got=%b required=%b", c, {green, yellow, red, phase}, model_out());
            end
            tick = 1'($urandom_range(0, 1));
            req  = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) flash = ~flash;
            if (c > 480) flash = 1'b0;
        end
    endtask

    initial begin
        rst    = 1'b1;
        tick   = 1'b0;
        req    = 2'b00;
        flash  = 1'b0;
        tick3  = 1'b0;
        req3   = 3'b000;
        flash3 = 1'b0;
        test_reset();
        test_n3();
        test_tick4();
        test_flash();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
